// File: rtl/block_memory_pkg.sv
// Shared definitions for the block memory and the cache controller that drives it.
package block_memory_pkg;

  localparam int DEF_BLOCK_BITS = 128;  // four 32-bit words per block
  localparam int DEF_ADDR_BITS  = 28;   // block address = byte address [31:4]
  localparam int DEF_MEM_BLOCKS = 256;  // power of two
  localparam int DEF_LATENCY    = 4;    // access cycles, at least 1

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // The latency counter must hold LATENCY-1 and be at least one bit wide.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/block_memory_if.sv
// Request/response bus between the cache controller (master) and block memory (slave).
interface block_memory_if
  import block_memory_pkg::*;
#(
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int BLOCK_BITS = DEF_BLOCK_BITS
);

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [BLOCK_BITS-1:0] mem_writedata;
  logic [BLOCK_BITS-1:0] mem_readdata;
  logic                  mem_busywait;

  modport master (
    output mem_read, mem_write, mem_addr, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_writedata,
    output mem_readdata, mem_busywait
  );

endinterface

// File: rtl/block_memory_ram.sv
// Single-port synchronous block RAM: one read or one write per enabled edge.
module block_ram #(
  parameter int BLOCK_BITS = 128,
  parameter int MEM_BLOCKS = 256,
  parameter int IDX_W      = $clog2(MEM_BLOCKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [BLOCK_BITS-1:0] i_wdata,
  output logic [BLOCK_BITS-1:0] o_rdata
);

  logic [BLOCK_BITS-1:0] r_mem [MEM_BLOCKS];
  logic [BLOCK_BITS-1:0] r_rdata;

  // Array write port.
  // NOTE: the storage array has no reset branch on purpose; contents survive
  // rst, and a reset loop over every entry would not map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Registered read data; only reads update it, so it holds across writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/block_memory.sv
// Fixed-latency block memory: accepts one refill or writeback at a time,
// reports busy for LATENCY+1 cycles, then a single DONE cycle.
module block_memory
  import block_memory_pkg::*;
#(
  parameter int BLOCK_BITS = DEF_BLOCK_BITS,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int MEM_BLOCKS = DEF_MEM_BLOCKS,
  parameter int LATENCY    = DEF_LATENCY
) (
  input logic          clk,
  input logic          rst,
  block_memory_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_BLOCKS);
  localparam int CNT_W = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_t r_state;
  mem_state_t w_next_state;

  logic [CNT_W-1:0]      r_count;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_is_write;
  logic [BLOCK_BITS-1:0] r_wdata;

  logic                  w_req;
  logic                  w_accept;
  logic                  w_count_done;
  logic                  w_ram_en;
  logic                  w_busywait;
  logic [BLOCK_BITS-1:0] w_rdata;
  logic                  w_addr_unused;

  assign w_req        = bus.mem_read | bus.mem_write;
  assign w_count_done = (r_count == '0);

  // Upper address bits do not select storage; addresses wrap modulo MEM_BLOCKS.
  assign w_addr_unused = ^bus.mem_addr[ADDR_BITS-1:IDX_W];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode; rst overrides every output to idle values.
  // NOTE: each output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_ram_en     = 1'b0;
    w_busywait   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_busywait   = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        w_busywait = 1'b1;
        if (w_count_done) begin
          w_ram_en     = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    if (rst) begin
      w_accept   = 1'b0;
      w_ram_en   = 1'b0;
      w_busywait = 1'b0;
    end
  end

  // Request capture at acceptance and latency countdown while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_idx      <= '0;
      r_is_write <= 1'b0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_count    <= CNT_LOAD;
      r_idx      <= bus.mem_addr[IDX_W-1:0];
      r_is_write <= bus.mem_write;  // write wins when both are requested
      r_wdata    <= bus.mem_writedata;
    end else if ((r_state == BUSY) && !w_count_done) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  block_ram #(
    .BLOCK_BITS (BLOCK_BITS),
    .MEM_BLOCKS (MEM_BLOCKS),
    .IDX_W      (IDX_W)
  ) u_block_ram (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_ram_en),
    .i_we    (r_is_write),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign bus.mem_readdata = w_rdata;
  assign bus.mem_busywait = w_busywait;

endmodule

// File: doc/block_memory.md
BLOCK_MEMORY -- requirements
Module: block_memory

Interface
REQ-001 SHALL have parameter BLOCK_BITS, default 128: bits per cache block, four 32-bit words.
REQ-002 SHALL have parameter ADDR_BITS, default 28: width of the block address (byte address [31:4]).
REQ-003 SHALL have parameter MEM_BLOCKS, default 256: number of stored blocks, a power of 2.
REQ-004 SHALL have parameter LATENCY, default 4: access cycles, minimum 1.
REQ-005 SHALL have clk  input  1: clock; all state updates on the rising edge.
REQ-006 SHALL have rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have mem_read  input  1: block refill request from the cache controller.
REQ-008 SHALL have mem_write  input  1: block writeback request from the cache controller.
REQ-009 SHALL have mem_addr  input  ADDR_BITS: block address.
REQ-010 SHALL have mem_writedata  input  BLOCK_BITS: writeback block.
REQ-011 SHALL have mem_readdata  output  BLOCK_BITS: refill block.
REQ-012 SHALL have mem_busywait  output  1: high while a request is outstanding; the cache holds its request stable while this is high.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 In IDLE with mem_read or mem_write high, SHALL do all of the following: drive mem_busywait high combinationally in the same cycle; latch address, op and writedata; load counter with LATENCY-1; go to BUSY.
REQ-015 In BUSY, SHALL hold mem_busywait high, decrement the counter each cycle, and ignore all request inputs; latched values are used.
REQ-016 In BUSY with counter==0, SHALL on that edge do the following, then go to DONE: for a read, register array[idx] into mem_readdata; for a write, write the latched data to array[idx].
REQ-017 In DONE, SHALL drive mem_busywait low for exactly one cycle, with mem_readdata valid for a read; it SHALL go to IDLE unconditionally and SHALL NOT accept requests in DONE.
REQ-018 Request at cycle t (IDLE) SHALL see mem_busywait low at cycle t+LATENCY+1, i.e. LATENCY+1 busy cycles.
REQ-019 Requests still asserted in IDLE after DONE SHALL be treated as new requests (back-to-back allowed, one idle gap of zero busy cycles = none; busywait re-asserts immediately).
REQ-020 When mem_read and mem_write are both high at acceptance, SHALL perform the write only.
REQ-021 SHALL compute idx = latched mem_addr modulo MEM_BLOCKS (low log2(MEM_BLOCKS) bits); upper address bits ignored, so addresses wrap.
REQ-022 mem_readdata SHALL hold its last value outside DONE; writes SHALL NOT alter mem_readdata.
REQ-023 With no request in IDLE, mem_busywait SHALL be 0.

Reset
REQ-024 On rst, SHALL set state to IDLE, counter to 0, mem_readdata to 0 and mem_busywait to 0 (combinationally low during rst).
REQ-025 Reset mid-BUSY SHALL abort the access; a pending write SHALL NOT be committed.
REQ-026 Array contents SHALL NOT be cleared by reset; the simulation preload SHALL be zero.
REQ-027 rst SHALL take priority over any request in the same cycle.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the defaults for BLOCK_BITS, ADDR_BITS, MEM_BLOCKS and LATENCY, shared with the cache controller.
REQ-029 Storage SHALL be a single sub-module block_ram (1 read/write port, synchronous, MEM_BLOCKS x BLOCK_BITS); FSM and counter reside in block_memory.

Verification (LATENCY=4)
REQ-030 Write addr 0x05, data 0x1111_2222_3333_4444_5555_6666_7777_8888 at t=0 -> busywait high for cycles 0-4 and low at 5; then read 0x05 -> same data in readdata at DONE.
REQ-031 Read addr 0x105 (MEM_BLOCKS=256) after the previous write -> returns block of 0x05 (wrap).
REQ-032 Change mem_addr to 0x07 and writedata during BUSY of a write to 0x06 -> only 0x06 is updated and 0x07 is unchanged.
REQ-033 Assert rst at cycle 2 of a write to 0x09 of 0xFF..FF -> busywait 0 next cycle, and a subsequent read of 0x09 returns 0.
REQ-034 Hold mem_read high continuously on 0x05 -> busywait pattern 5 high / 1 low repeating, with readdata valid each DONE.
REQ-035 mem_read and mem_write both high on 0x0A with data 0xAB.. -> write committed, and a later read of 0x0A returns 0xAB..
